seq_serializer: RTL
===================

// Module: seq_serializer
// PURPOSE
//   Upstream feeder for the 101 Moore sequence detector. Accepts parallel words over a
//   valid/ready handshake and shifts them out MSB-first, one bit per clock, on ser_o.
//   ser_o drives the detector's seq_in. A one-word holding register sustains back-to-back
//   frames with no gap bit. Between frames ser_o holds IDLE_BIT.
// PARAMETERS
//   WIDTH     8    data bits per frame (>=2)
//   IDLE_BIT  1'b0 ser_o value while no frame is shifting
// PORTS
//   clock       in   1      single clock, all logic on posedge
//   reset       in   1      synchronous, active-high
//   din         in   WIDTH  parallel word, bit WIDTH-1 sent first
//   din_valid   in   1      din presented
//   din_ready   out  1      word accepted on edge where din_valid && din_ready
//   ser_o       out  1      serial bit (registered)
//   ser_valid   out  1      ser_o carries frame data this cycle
//   frame_done  out  1      1-cycle pulse, high coincident with last bit of a frame
//   busy        out  1      shift register or holding register occupied
// BEHAVIOUR
//   - Reset (sync): state=IDLE, cnt=0, hold_full=0, ser_o=IDLE_BIT, ser_valid=0,
//     frame_done=0, busy=0. din_ready is forced 0 while reset=1; words offered then are dropped.
//   - din_ready = !hold_full && !reset (combinational).
//   - FSM states (seq_pkg::ser_state_t): IDLE, SHIFT.
//     - IDLE and accept: shift_reg<=din, cnt<=0, go to SHIFT.
//       First bit appears on ser_o the cycle after the accept edge (latency 1).
//     - SHIFT, not last bit: shift left, cnt++.
//       If accept occurs here, the word goes to the holding register (hold_full<=1).
//     - SHIFT, last bit (cnt==FRAME_LEN-1), frame_done=1:
//       - hold_full: shift_reg<=hold, hold_full<=0, stay in SHIFT (no gap cycle).
//       - hold empty and accept this edge: bypass din straight into shift_reg, stay in SHIFT.
//       - otherwise: go to IDLE. ser_o<=IDLE_BIT and ser_valid<=0 on the next cycle.
//   - FRAME_LEN = WIDTH, or WIDTH+1 with parity. cnt width = $clog2(WIDTH+2).
//     cnt never exceeds FRAME_LEN-1 and is reset to 0 on every frame load.
//   - At most two words are outstanding: the one shifting plus the one held.
//     din_ready deasserts while hold_full=1.
//   - Reset mid-frame: the current frame and the held word are discarded and not resumed.
//   - din_valid may drop without an accept. No data is latched unless the handshake completes.
// CONFIGURATION
//   SEQ_SER_PARITY_EN defined:
//     - one even-parity bit (^data) is appended after the data bits; FRAME_LEN=WIDTH+1.
//     - parity is computed at load time and stored alongside shift_reg.
//     - frame_done is high on the parity bit.
//   SEQ_SER_PARITY_EN undefined: FRAME_LEN=WIDTH, no parity logic or storage is built.
// STRUCTURE
//   - seq_pkg (shared with the detector):
//     - ser_state_t enum {IDLE, SHIFT}.
//     - detector state encodings IDLE/STATE1/STATE2/STATE3 as localparams.
//     - DEFAULT_WIDTH=8.
//   - No sub-module: the counter, shift register and holding register are inline.
//     The block is flat and sized ~150-250 lines.
// TESTING (WIDTH=8, IDLE_BIT=0; golden 101 detector instantiated on ser_o)
//   1 Single word 8'hA0 accepted at edge 0:
//     - ser_o=1,0,1,0,0,0,0,0 in cycles 1-8, ser_valid=1 cycles 1-8.
//     - frame_done=1 cycle 8 only.
//     - detector det_o=1 one cycle after the third bit.
//   2 Back-to-back 8'hA5 then 8'h5A, din_valid held high:
//     - 16 contiguous ser_valid cycles, bitstream 1010_0101_0101_1010.
//     - din_ready=0 while hold_full.
//     - frame_done at bits 8 and 16.
//   3 Overlap check, word 8'b1010_1010:
//     - detector asserts det_o three times (overlapping 101).
//     - ser_o=0 and ser_valid=0 after bit 8.
//   4 Reset asserted after 3 bits of 8'hFF with 8'h0F held:
//     - next cycle ser_o=0, ser_valid=0, busy=0, din_ready=0 during reset, 1 after.
//     - 8'h0F is never transmitted.
//   5 Idle line, din_valid=0 for 20 cycles:
//     - ser_o=0, ser_valid=0, frame_done=0, detector det_o stays 0.
//   6 SEQ_SER_PARITY_EN, word 8'h07:
//     - 9 bits 0000_0111 then parity 1.
//     - frame_done on bit 9; next word's first bit on cycle 10 if it was held.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: definitions shared by the 101 sequence detector and its serializer feeder.
//   DEFAULT_WIDTH  default parallel word width for seq_serializer
//   ser_state_t    serializer FSM states (IDLE, SHIFT)
//   DET_*          Moore 101 detector state encodings
package seq_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE,
        SHIFT
    } ser_state_t;

    // Prefixed so they do not collide with the ser_state_t IDLE literal.
    localparam logic [1:0] DET_IDLE   = 2'd0;
    localparam logic [1:0] DET_STATE1 = 2'd1;
    localparam logic [1:0] DET_STATE2 = 2'd2;
    localparam logic [1:0] DET_STATE3 = 2'd3;

endpackage

// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial feeder for the 101 sequence detector.
// Words arrive on a valid/ready handshake and leave MSB-first on ser_o, one bit
// per clock. A one-word holding register lets the next frame follow with no gap.
//
// Ports:
//   clock       in   single clock, posedge
//   reset       in   synchronous, active-high
//   din         in   parallel word, bit WIDTH-1 sent first
//   din_valid   in   din presented
//   din_ready   out  word accepted on edge where din_valid && din_ready
//   ser_o       out  serial bit (registered), IDLE_BIT between frames
//   ser_valid   out  ser_o carries frame data
//   frame_done  out  high with the last bit of a frame
//   busy        out  shift or holding register occupied
//
// Configuration: define SEQ_SER_PARITY_EN to append an even-parity bit to each
// frame (frame length WIDTH+1, frame_done on the parity bit).
module seq_serializer
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_o,
    output logic             ser_valid,
    output logic             frame_done,
    output logic             busy
);

`ifdef SEQ_SER_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif
    localparam int unsigned        CNT_W    = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(FRAME_LEN - 1);

    // Frame image as it is shifted out; parity (when built) is fixed at load time.
    function automatic logic [FRAME_LEN-1:0] frame_of(input logic [WIDTH-1:0] w);
`ifdef SEQ_SER_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    ser_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_LEN-1:0] shift_q, shift_d;
    logic [FRAME_LEN-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 ser_q, ser_d;
    logic                 ser_valid_q, ser_valid_d;
    logic                 frame_done_q, frame_done_d;
    logic                 accept;

    assign din_ready = !hold_full_q && !reset;
    assign accept    = din_valid && din_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = frame_of(din);
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != LAST_CNT) begin
                    shift_d = {shift_q[FRAME_LEN-2:0], 1'b0};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (accept) begin
                        hold_d      = frame_of(din);
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                end else if (accept) begin
                    // Hold is empty on the last bit: load din directly, no gap cycle.
                    shift_d = frame_of(din);
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from next-state values so ser_o lines up with cnt.
        ser_valid_d  = (state_d == SHIFT);
        ser_d        = ser_valid_d ? shift_d[FRAME_LEN-1] : IDLE_BIT;
        frame_done_d = ser_valid_d && (cnt_d == LAST_CNT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            ser_q        <= IDLE_BIT;
            ser_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            ser_q        <= ser_d;
            ser_valid_q  <= ser_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ser_o      = ser_q;
    assign ser_valid  = ser_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q == SHIFT) || hold_full_q;

endmodule
